pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have the parameter RESET_PC, default 32'hBFC0_0000, giving the fetch address loaded on reset.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have the port stall_i, input, 1 bit: pipeline stall; PC holds while high.
REQ-005 The block SHALL have the ports branch_taken_i (input, 1 bit), branch_base_i (input, 32 bits, PC of the branch + 4) and branch_offset_i (input, 32 bits, sign-extended word offset): the conditional-branch redirect request.
REQ-006 The block SHALL have the ports jump_i (input, 1 bit) and jump_index_i (input, 26 bits): the J/JAL redirect request.
REQ-007 The block SHALL have the ports jr_i (input, 1 bit) and jr_target_i (input, 32 bits): the JR/JALR redirect request.
REQ-008 The block SHALL have the ports exc_i (input, 1 bit) and exc_vector_i (input, 32 bits): the exception/ERET redirect request.
REQ-009 The block SHALL have the port inst_sram_en, output, 1 bit: instruction fetch enable.
REQ-010 The block SHALL have the port inst_sram_addr, output, 32 bits: fetch address, equal to pc_o.
REQ-011 The block SHALL have the port pc_o, output, 32 bits: the current PC register.
REQ-012 The block SHALL have the port pend_o, output, 1 bit: a redirect is captured and waiting for the stall to clear.
REQ-013 The block SHALL have the port adel_o, output, 1 bit: pc_o[1:0] != 2'b00 (fetch address error).

Function
REQ-014 Target arithmetic SHALL be modulo 2^32, as follows:
- Branch target = branch_base_i + {branch_offset_i[29:0], 2'b00}.
- Jump target = {branch_base_i[31:28], jump_index_i, 2'b00}.
- JR target = jr_target_i.
- Exception target = exc_vector_i.
REQ-015 Redirect priority SHALL be exc_i > jr_i > jump_i > branch_taken_i; only the highest-priority asserted request is used.
REQ-016 The state machine SHALL have three states: BOOT, RUN and PEND.
REQ-017 BOOT SHALL be entered on reset and SHALL last one cycle with inst_sram_en=0, then go to RUN unconditionally, with pc_o unchanged.
REQ-018 In RUN with stall_i=0, the next PC SHALL be the selected redirect target if any request is asserted, otherwise pc_o+4.
REQ-019 In RUN with stall_i=1, pc_o SHALL hold, and if a request is asserted its target SHALL be latched into a pending register with a transition to PEND.
REQ-020 In PEND with stall_i=1, pc_o SHALL hold and the pending target SHALL be kept, except that an asserted exc_i SHALL overwrite the pending target.
REQ-021 In PEND with stall_i=0, pc_o SHALL load the pending target (or exc_vector_i if exc_i is asserted that cycle) and the state SHALL return to RUN.
REQ-022 exc_i SHALL take effect even when stall_i=1: pc_o loads exc_vector_i on that edge and the state goes to RUN, discarding any pending target.
REQ-023 Branch-delay-slot semantics SHALL be preserved:
- The request arrives while the delay slot is being fetched.
- The target is the next fetched address.
- No extra PC+4 is inserted.
REQ-024 inst_sram_en SHALL be 1 in RUN and PEND and 0 in BOOT; while stall_i=1 the address SHALL be held, not dropped.
REQ-025 pend_o SHALL be 1 exactly when the state is PEND.
REQ-026 adel_o SHALL be combinational from pc_o; a misaligned target is loaded unchanged, not corrected.
REQ-027 Wrap-around SHALL be silent: pc_o=32'hFFFF_FFFC with no redirect goes to 32'h0000_0000.

Reset
REQ-028 While rst=1, and asynchronously on its rising edge, the block SHALL set:
- pc_o = RESET_PC, state = BOOT, pending register = 0;
- inst_sram_en = 0, pend_o = 0, adel_o = 0.
REQ-029 Reset asserted mid-operation, including in PEND, SHALL discard any pending redirect; the first fetch after release SHALL be at RESET_PC in the cycle after BOOT.

Verification
REQ-030 Scenario, reset release with no requests: inst_sram_en=0 for 1 cycle, then addresses BFC00000, BFC00004 and BFC00008 on consecutive cycles.
REQ-031 Scenario, branch: pc_o=BFC00010, branch_taken_i=1, branch_base_i=BFC0000C, branch_offset_i=FFFF_FFFE: next pc_o=BFC00004.
REQ-032 Scenario, jump plus branch in the same cycle: jump_i=1, jump_index_i=26'h0000040, branch_base_i=BFC00100, branch_taken_i=1: jump wins and next pc_o=B0000100.
REQ-033 Scenario, stall: stall_i=1 for 3 cycles while jr_i=1 with jr_target_i=80001000 in the first cycle only: pc_o holds and pend_o=1 for 3 cycles, then pc_o=80001000 with pend_o=0.
REQ-034 Scenario, exception while pending: a redirect is pending and stall_i=1, then exc_i=1 with exc_vector_i=BFC00380: next pc_o=BFC00380, pend_o=0, and the stale target is never fetched.
REQ-035 Scenario, misaligned JR and mid-run reset: jr_target_i=80000002 gives pc_o=80000002 with adel_o=1; rst pulsed mid-PEND gives pc_o=BFC00000 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: sequential fetch, prioritised redirects, and stall-time capture of
// redirect targets so that a delay-slot redirect is not lost while the pipeline is held.
//
// state | meaning
// BOOT  | first cycle after reset, fetch disabled, PC held at RESET_PC
// RUN   | normal fetch, PC advances by 4 or jumps to a redirect target
// PEND  | stalled with a captured redirect target waiting to be loaded
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_base_i,
    input  logic [31:0] branch_offset_i,
    input  logic        jump_i,
    input  logic [25:0] jump_index_i,
    input  logic        jr_i,
    input  logic [31:0] jr_target_i,
    input  logic        exc_i,
    input  logic [31:0] exc_vector_i,
    output logic        inst_sram_en,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] pc_o,
    output logic        pend_o,
    output logic        adel_o
);

    typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;
    logic [31:0] branch_tgt;
    logic [31:0] jump_tgt;
    logic [31:0] redir_tgt;
    logic        req_any;
    logic        unused_offset_hi;

    // The word offset is shifted left by two, so its top two bits fall off.
    assign unused_offset_hi = ^branch_offset_i[31:30];
    assign branch_tgt       = branch_base_i + {branch_offset_i[29:0], 2'b00};
    assign jump_tgt         = {branch_base_i[31:28], jump_index_i, 2'b00};
    assign req_any          = exc_i | jr_i | jump_i | branch_taken_i;

    always_comb begin
        redir_tgt = branch_tgt;
        if (exc_i) begin
            redir_tgt = exc_vector_i;
        end else if (jr_i) begin
            redir_tgt = jr_target_i;
        end else if (jump_i) begin
            redir_tgt = jump_tgt;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (exc_i) begin
                    pc_d = exc_vector_i;
                end else if (!stall_i) begin
                    pc_d = req_any ? redir_tgt : pc_q + 32'd4;
                end else if (req_any) begin
                    pend_d  = redir_tgt;
                    state_d = PEND;
                end
            end
            PEND: begin
                // An exception is taken immediately even under stall and drops the stale target.
                if (exc_i) begin
                    pc_d    = exc_vector_i;
                    pend_d  = 32'd0;
                    state_d = RUN;
                end else if (!stall_i) begin
                    pc_d    = pend_q;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            pend_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
        end
    end

    assign pc_o           = pc_q;
    assign inst_sram_addr = pc_q;
    assign inst_sram_en   = (state_q != BOOT);
    assign pend_o         = (state_q == PEND);
    assign adel_o         = (pc_q[1:0] != 2'b00);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: each task drives one scenario and checks against
// hand-computed addresses.
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        branch_taken_i;
    logic [31:0] branch_base_i;
    logic [31:0] branch_offset_i;
    logic        jump_i;
    logic [25:0] jump_index_i;
    logic        jr_i;
    logic [31:0] jr_target_i;
    logic        exc_i;
    logic [31:0] exc_vector_i;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] pc_o;
    logic        pend_o;
    logic        adel_o;

    int n_cmp;
    int n_err;

    pc_sequencer #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall_i),
        .branch_taken_i (branch_taken_i),
        .branch_base_i  (branch_base_i),
        .branch_offset_i(branch_offset_i),
        .jump_i         (jump_i),
        .jump_index_i   (jump_index_i),
        .jr_i           (jr_i),
        .jr_target_i    (jr_target_i),
        .exc_i          (exc_i),
        .exc_vector_i   (exc_vector_i),
        .inst_sram_en   (inst_sram_en),
        .inst_sram_addr (inst_sram_addr),
        .pc_o           (pc_o),
        .pend_o         (pend_o),
        .adel_o         (adel_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        stall_i         = 1'b0;
        branch_taken_i  = 1'b0;
        branch_base_i   = 32'd0;
        branch_offset_i = 32'd0;
        jump_i          = 1'b0;
        jump_index_i    = 26'd0;
        jr_i            = 1'b0;
        jr_target_i     = 32'd0;
        exc_i           = 1'b0;
        exc_vector_i    = 32'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_req();
        #1;
        n_cmp++;
        if (pc_o !== 32'hBFC0_0000) begin n_err++; $display("FAIL reset_pc got=%h exp=%h", pc_o, 32'hBFC0_0000); end
        n_cmp++;
        if ({inst_sram_en, pend_o, adel_o} !== 3'b000) begin
            n_err++; $display("FAIL reset_flags got=%b exp=000", {inst_sram_en, pend_o, adel_o});
        end
        step();
        step();
        rst = 1'b0;
        n_cmp++;
        if (inst_sram_en !== 1'b0 || pc_o !== 32'hBFC0_0000) begin
            n_err++; $display("FAIL boot_cycle en=%b pc=%h exp en=0 pc=bfc00000", inst_sram_en, pc_o);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_addr [3];
        exp_addr[0] = 32'hBFC0_0000;
        exp_addr[1] = 32'hBFC0_0004;
        exp_addr[2] = 32'hBFC0_0008;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (inst_sram_en !== 1'b1 || inst_sram_addr !== exp_addr[i]) begin
                n_err++; $display("FAIL seq_fetch[%0d] en=%b addr=%h exp en=1 addr=%h", i, inst_sram_en, inst_sram_addr, exp_addr[i]);
            end
        end
    endtask

    task automatic test_branch();
        step();
        step();
        n_cmp++;
        if (pc_o !== 32'hBFC0_0010) begin n_err++; $display("FAIL pre_branch_pc got=%h exp=bfc00010", pc_o); end
        branch_taken_i  = 1'b1;
        branch_base_i   = 32'hBFC0_000C;
        branch_offset_i = 32'hFFFF_FFFE;
        step();
        clear_req();
        n_cmp++;
        if (pc_o !== 32'hBFC0_0004) begin n_err++; $display("FAIL branch_back got=%h exp=bfc00004", pc_o); end
    endtask

    task automatic test_jump_over_branch();
        jump_i          = 1'b1;
        jump_index_i    = 26'h000_0040;
        branch_base_i   = 32'hBFC0_0100;
        branch_taken_i  = 1'b1;
        branch_offset_i = 32'h0000_0010;
        step();
        clear_req();
        n_cmp++;
        if (pc_o !== 32'hB000_0100) begin n_err++; $display("FAIL jump_wins got=%h exp=b0000100", pc_o); end
    endtask

    task automatic test_priority();
        exc_i          = 1'b1;
        exc_vector_i   = 32'h0000_0080;
        jr_i           = 1'b1;
        jr_target_i    = 32'h0000_0800;
        jump_i         = 1'b1;
        jump_index_i   = 26'h000_0123;
        branch_taken_i = 1'b1;
        branch_base_i  = 32'h0000_1000;
        step();
        n_cmp++;
        if (pc_o !== 32'h0000_0080) begin n_err++; $display("FAIL exc_over_all got=%h exp=00000080", pc_o); end
        exc_i       = 1'b0;
        jr_target_i = 32'h0000_0400;
        step();
        clear_req();
        n_cmp++;
        if (pc_o !== 32'h0000_0400) begin n_err++; $display("FAIL jr_over_jump got=%h exp=00000400", pc_o); end
    endtask

    task automatic test_stall_pend();
        stall_i     = 1'b1;
        jr_i        = 1'b1;
        jr_target_i = 32'h8000_1000;
        for (int i = 0; i < 3; i++) begin
            step();
            jr_i        = 1'b0;
            jr_target_i = 32'h0;
            n_cmp++;
            if (pc_o !== 32'h0000_0400 || pend_o !== 1'b1 || inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h0000_0400) begin
                n_err++;
                $display("FAIL stall_hold[%0d] pc=%h pend=%b en=%b addr=%h exp pc=00000400 pend=1 en=1 addr=00000400",
                         i, pc_o, pend_o, inst_sram_en, inst_sram_addr);
            end
        end
        stall_i = 1'b0;
        step();
        n_cmp++;
        if (pc_o !== 32'h8000_1000 || pend_o !== 1'b0) begin
            n_err++; $display("FAIL stall_release pc=%h pend=%b exp pc=80001000 pend=0", pc_o, pend_o);
        end
    endtask

    task automatic test_exc_pending();
        stall_i         = 1'b1;
        branch_taken_i  = 1'b1;
        branch_base_i   = 32'h8000_1004;
        branch_offset_i = 32'h0000_0004;
        step();
        branch_taken_i = 1'b0;
        n_cmp++;
        if (pend_o !== 1'b1 || pc_o !== 32'h8000_1000) begin
            n_err++; $display("FAIL exc_setup pend=%b pc=%h exp pend=1 pc=80001000", pend_o, pc_o);
        end
        exc_i        = 1'b1;
        exc_vector_i = 32'hBFC0_0380;
        step();
        exc_i = 1'b0;
        n_cmp++;
        if (pc_o !== 32'hBFC0_0380 || pend_o !== 1'b0) begin
            n_err++; $display("FAIL exc_in_pend pc=%h pend=%b exp pc=bfc00380 pend=0", pc_o, pend_o);
        end
        step();
        stall_i = 1'b0;
        step();
        clear_req();
        n_cmp++;
        if (pc_o !== 32'hBFC0_0384) begin n_err++; $display("FAIL no_stale_fetch got=%h exp=bfc00384", pc_o); end
    endtask

    task automatic test_exc_run_stall();
        stall_i = 1'b1;
        step();
        n_cmp++;
        if (pc_o !== 32'hBFC0_0384 || pend_o !== 1'b0) begin
            n_err++; $display("FAIL stall_no_req pc=%h pend=%b exp pc=bfc00384 pend=0", pc_o, pend_o);
        end
        exc_i        = 1'b1;
        exc_vector_i = 32'h0000_1000;
        step();
        clear_req();
        n_cmp++;
        if (pc_o !== 32'h0000_1000 || pend_o !== 1'b0) begin
            n_err++; $display("FAIL exc_under_stall pc=%h pend=%b exp pc=00001000 pend=0", pc_o, pend_o);
        end
    endtask

    task automatic test_wrap();
        jr_i        = 1'b1;
        jr_target_i = 32'hFFFF_FFFC;
        step();
        clear_req();
        n_cmp++;
        if (pc_o !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_setup got=%h exp=fffffffc", pc_o); end
        step();
        n_cmp++;
        if (pc_o !== 32'h0000_0000) begin n_err++; $display("FAIL wrap_zero got=%h exp=00000000", pc_o); end
    endtask

    task automatic test_back_to_back();
        jr_i        = 1'b1;
        jr_target_i = 32'h0000_0100;
        step();
        clear_req();
        branch_taken_i  = 1'b1;
        branch_base_i   = 32'h0000_0104;
        branch_offset_i = 32'h0000_0003;
        n_cmp++;
        if (pc_o !== 32'h0000_0100) begin n_err++; $display("FAIL b2b_first got=%h exp=00000100", pc_o); end
        step();
        clear_req();
        n_cmp++;
        if (pc_o !== 32'h0000_0110) begin n_err++; $display("FAIL b2b_second got=%h exp=00000110", pc_o); end
        step();
        n_cmp++;
        if (pc_o !== 32'h0000_0114) begin n_err++; $display("FAIL b2b_seq got=%h exp=00000114", pc_o); end
    endtask

    task automatic test_misaligned();
        jr_i        = 1'b1;
        jr_target_i = 32'h8000_0002;
        step();
        clear_req();
        n_cmp++;
        if (pc_o !== 32'h8000_0002 || adel_o !== 1'b1) begin
            n_err++; $display("FAIL misaligned_jr pc=%h adel=%b exp pc=80000002 adel=1", pc_o, adel_o);
        end
        step();
        n_cmp++;
        if (pc_o !== 32'h8000_0006 || adel_o !== 1'b1) begin
            n_err++; $display("FAIL misaligned_seq pc=%h adel=%b exp pc=80000006 adel=1", pc_o, adel_o);
        end
    endtask

    task automatic test_reset_mid_pend();
        stall_i     = 1'b1;
        jr_i        = 1'b1;
        jr_target_i = 32'h8000_2000;
        step();
        clear_req();
        stall_i = 1'b1;
        n_cmp++;
        if (pend_o !== 1'b1) begin n_err++; $display("FAIL pend_before_rst got=%b exp=1", pend_o); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (pc_o !== 32'hBFC0_0000 || pend_o !== 1'b0 || inst_sram_en !== 1'b0 || adel_o !== 1'b0) begin
            n_err++;
            $display("FAIL async_rst pc=%h pend=%b en=%b adel=%b exp pc=bfc00000 pend=0 en=0 adel=0",
                     pc_o, pend_o, inst_sram_en, adel_o);
        end
        #1;
        rst     = 1'b0;
        stall_i = 1'b0;
        step();
        n_cmp++;
        if (inst_sram_en !== 1'b1 || pc_o !== 32'hBFC0_0000) begin
            n_err++; $display("FAIL post_rst_first en=%b pc=%h exp en=1 pc=bfc00000", inst_sram_en, pc_o);
        end
        step();
        n_cmp++;
        if (pc_o !== 32'hBFC0_0004 || pend_o !== 1'b0) begin
            n_err++; $display("FAIL post_rst_discard pc=%h pend=%b exp pc=bfc00004 pend=0", pc_o, pend_o);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_sequential();
        test_branch();
        test_jump_over_branch();
        test_priority();
        test_stall_pend();
        test_exc_pending();
        test_exc_run_stall();
        test_wrap();
        test_back_to_back();
        test_misaligned();
        test_reset_mid_pend();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
